jbu_pred: RTL
=============

Name: jbu_pred

Overview:
- Pipelined, parametrised jump/branch resolution unit with an integrated bimodal branch history table (BHT).
- Resolves branch conditions and jump/branch targets, and flags mispredictions against the fetch-time prediction.
- Trains per-PC 2-bit saturating counters.
- Sits in the IEU execute stage. A valid/ready handshake on both sides and a single registered output stage give 1-cycle latency; a combinational lookup port serves fetch.

Parameters:
XLEN, 32, data/address width
BHT_DEPTH, 64, number of BHT entries; power of two, >= 2
IDX_W, $clog2(BHT_DEPTH), BHT index width (derived, not overridden)

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
flush  input  1  drop in-flight result, block acceptance this cycle
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
jump  input  1  JAL/JALR
jalr  input  1  qualifies jump as JALR
branch  input  1  conditional branch
funct3  input  3  branch condition
pc  input  XLEN  instruction PC
imm  input  XLEN  sign-extended immediate
rs1_data  input  XLEN  operand 1
rs2_data  input  XLEN  operand 2
pred_taken  input  1  fetch-time taken prediction
res_valid  output  1  result valid
res_ready  input  1  consumer ready
jack  output  1  op was a jump or branch
je  output  1  taken
target  output  XLEN  computed target
redirect_pc  output  XLEN  architecturally correct next PC
mispredict  output  1  jack && (je != pred_taken)
lookup_pc  input  XLEN  fetch PC to predict
lookup_taken  output  1  BHT prediction for lookup_pc

Behaviour:
- Reset (reset_n low at clk edge): res_valid=0; jack, je, mispredict=0; target, redirect_pc=0; every BHT counter = 2'b01 (weakly not-taken).
- Reset applies mid-operation. Any held result is discarded.
- in_ready = !flush && (!res_valid || res_ready). Deasserted while reset_n is low.
- Accept: on in_valid && in_ready, results are registered and res_valid=1 next cycle (latency 1). Full throughput when res_ready is held high.
- Hold: res_valid && !res_ready keeps all outputs stable.
- Otherwise, when res_ready is high and nothing is accepted, res_valid drops to 0.
- Flush: res_valid=0 next cycle, regardless of res_ready. No acceptance and no BHT update that cycle.
- Condition for branch:
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011 give jack=1, je=0.
- jump has priority: if jump=1, then jack=1 and je=1 regardless of branch or funct3.
- jalr is ignored unless jump=1.
- target:
  - jump && jalr: (rs1_data + imm) with bit 0 cleared.
  - Otherwise: pc + imm.
  - Arithmetic is modulo 2^XLEN; wrap-around is silent.
- redirect_pc = je ? target : pc + 4 (mod 2^XLEN).
- No jump or branch: jack=0, je=0, mispredict=0, redirect_pc = pc+4.
- BHT index = pc[IDX_W+1:2], for both update and lookup.
- BHT update happens only on an accepted request with branch=1 and jump=0:
  - Counter increments if je=1, else decrements.
  - Saturates at 2'b11 and 2'b00.
  - Jumps never train the BHT.
- lookup_taken = counter[1] of entry lookup_pc[IDX_W+1:2]. Purely combinational.
- Same-cycle lookup and update of the same index returns the pre-update value (read-before-write).
- mispredict is also asserted for jumps when pred_taken=0.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then release. Expect res_valid=0, in_ready=1, lookup_taken=0 for any lookup_pc.
- Signed vs unsigned: branch with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0:
  - BLT gives je=1, target=0x120, redirect_pc=0x120, mispredict=1.
  - BLTU gives je=0, redirect_pc=0x104, mispredict=0.
- JALR with rs1=0x1003, imm=0x4, branch=1, funct3=001: expect je=1, target=0x1006, mispredict=1 when pred_taken=0. BHT is unchanged.
- Counter training: four taken BEQ at pc=0x40 (rs1=rs2). After them lookup_pc=0x40 gives 1 and the counter is saturated at 11. Then two not-taken give 01 and lookup 0. Use a same-cycle lookup to check the old value is returned.
- Backpressure: accept A, then present B while res_ready=0 for 3 cycles. Expect A's outputs stable, in_ready=0, and B accepted exactly when res_ready rises. With res_ready=1 throughout, back-to-back ops give one result per cycle.
- Flush and wrap: flush while a result is held gives res_valid=0 next cycle and no BHT update. Separately, pc=0xFFFFFFFC, imm=8, taken branch gives target=0x4, and an untaken branch at the same pc gives redirect_pc=0x0.

Source files
------------

// File: rtl/jbu_pred_if.sv
// Handshake and data bundle between the execute stage and the jump/branch unit,
// plus the fetch-side BHT lookup port.
interface jbu_pred_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            pred_taken;
    logic            res_valid;
    logic            res_ready;
    logic            jack;
    logic            je;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirect_pc;
    logic            mispredict;
    logic [XLEN-1:0] lookup_pc;
    logic            lookup_taken;

    modport master (
        output flush, in_valid, jump, jalr, branch, funct3, pc, imm,
               rs1_data, rs2_data, pred_taken, res_ready, lookup_pc,
        input  in_ready, res_valid, jack, je, target, redirect_pc,
               mispredict, lookup_taken
    );

    modport slave (
        input  flush, in_valid, jump, jalr, branch, funct3, pc, imm,
               rs1_data, rs2_data, pred_taken, res_ready, lookup_pc,
        output in_ready, res_valid, jack, je, target, redirect_pc,
               mispredict, lookup_taken
    );
endinterface

// File: rtl/jbu_pred.sv
// Jump/branch resolution unit: resolves conditions and targets in one registered
// stage, flags mispredictions and trains a bimodal table of 2-bit counters.
module jbu_pred #(
    parameter  int XLEN      = 32,
    parameter  int BHT_DEPTH = 64,
    localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic      clk,
    input  logic      reset_n,
    jbu_pred_if.slave bus
);

    logic [1:0]      r_bht [BHT_DEPTH];
    logic            r_valid;
    logic            r_jack;
    logic            r_je;
    logic            r_mispredict;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_redirect;

    logic            w_cond;
    logic            w_jack;
    logic            w_je;
    logic [XLEN-1:0] w_sum_jalr;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redirect;
    logic            w_ready;
    logic            w_accept;
    logic            w_train;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_lkp_idx;
    logic [1:0]      w_ctr_next;
    logic            w_unused;

    assign w_upd_idx = bus.pc[IDX_W+1:2];
    assign w_lkp_idx = bus.lookup_pc[IDX_W+1:2];
    assign w_unused  = ^{bus.lookup_pc[XLEN-1:IDX_W+2], bus.lookup_pc[1:0]};

    // Branch condition decode; 010/011 are not real conditions and resolve not-taken.
    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3)
            3'b000:  w_cond = (bus.rs1_data == bus.rs2_data);
            3'b001:  w_cond = (bus.rs1_data != bus.rs2_data);
            3'b100:  w_cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'b101:  w_cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'b110:  w_cond = (bus.rs1_data <  bus.rs2_data);
            3'b111:  w_cond = (bus.rs1_data >= bus.rs2_data);
            default: w_cond = 1'b0;
        endcase
    end

    // Resolution: jump dominates branch; jalr only matters for jumps.
    always_comb begin
        w_jack     = bus.jump | bus.branch;
        w_je       = bus.jump | (bus.branch & w_cond);
        w_sum_jalr = bus.rs1_data + bus.imm;
        if (bus.jump && bus.jalr) begin
            w_target = {w_sum_jalr[XLEN-1:1], 1'b0};
        end else begin
            w_target = bus.pc + bus.imm;
        end
        w_redirect = w_je ? w_target : (bus.pc + XLEN'(4));
    end

    assign w_ready  = reset_n & ~bus.flush & (~r_valid | bus.res_ready);
    assign w_accept = bus.in_valid & w_ready;
    assign w_train  = w_accept & bus.branch & ~bus.jump;

    // Saturating next value for the counter of the accepted branch.
    always_comb begin
        w_ctr_next = r_bht[w_upd_idx];
        if (w_je) begin
            if (r_bht[w_upd_idx] != 2'b11) w_ctr_next = r_bht[w_upd_idx] + 2'd1;
        end else begin
            if (r_bht[w_upd_idx] != 2'b00) w_ctr_next = r_bht[w_upd_idx] - 2'd1;
        end
    end

    // Output stage and valid tracking; flush kills the held result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_jack       <= 1'b0;
            r_je         <= 1'b0;
            r_mispredict <= 1'b0;
            r_target     <= '0;
            r_redirect   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_jack       <= w_jack;
            r_je         <= w_je;
            r_mispredict <= w_jack & (w_je != bus.pred_taken);
            r_target     <= w_target;
            r_redirect   <= w_redirect;
        end else if (bus.res_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Counter table: reset to weakly not-taken, trained only by accepted branches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
        end else if (w_train) begin
            r_bht[w_upd_idx] <= w_ctr_next;
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.res_valid    = r_valid;
    assign bus.jack         = r_jack;
    assign bus.je           = r_je;
    assign bus.mispredict   = r_mispredict;
    assign bus.target       = r_target;
    assign bus.redirect_pc  = r_redirect;
    assign bus.lookup_taken = r_bht[w_lkp_idx][1];

endmodule
